// File: rtl/mem_port_arbiter.sv
// Arbiter that serialises instruction-fetch and data accesses onto one shared memory port
// and produces the pipeline enables once every access of the current slot has completed.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TMO_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              hz_pc_we,
    input  logic              hz_ifid_en,
    input  logic              hz_idex_en,
    input  logic              hz_exmem_en,
    input  logic              hz_memwb_en,
    output logic              pc_write_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                if_done_q, if_done_d;
    logic                dm_done_q, dm_done_d;
    logic                err_q, err_d;
    logic [TMO_W-1:0]    wdog_q, wdog_d;

    logic                adv;
    logic                need_dm;
    logic                need_if;
    logic                ack_v;
    logic                tmo;
    logic                acc_done;
    logic [TMO_W-1:0]    wdog_inc;
    logic [DATA_W-1:0]   cap_data;

    always_comb begin
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = if_done_q;
        dm_done_d   = dm_done_q;
        err_d       = err_q;
        wdog_d      = wdog_q;
        adv         = 1'b0;
        need_dm     = dm_req & ~dm_done_q;
        need_if     = if_req & ~if_done_q;
        ack_v       = mem_ack & mem_en_q;
        wdog_inc    = wdog_q + 1'b1;
        tmo         = 1'b0;
        acc_done    = 1'b0;
        cap_data    = '0;

        case (state_q)
            IDLE: begin
                // Data side wins: the MEM-stage instruction is older than the fetch.
                if (need_dm) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    wdog_d      = '0;
                    state_d     = DM_BUSY;
                end else if (need_if) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    wdog_d      = '0;
                    state_d     = IF_BUSY;
                end else begin
                    adv         = 1'b1;
                    if_done_d   = 1'b0;
                    dm_done_d   = 1'b0;
                end
            end
            DM_BUSY, IF_BUSY: begin
                // A watchdog expiry completes the access as if acked with zero data.
                tmo      = ~ack_v & (&wdog_inc);
                acc_done = ack_v | tmo;
                cap_data = ack_v ? mem_rdata : '0;
                if (acc_done) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    wdog_d   = '0;
                    err_d    = err_q | tmo;
                    state_d  = IDLE;
                    if (state_q == DM_BUSY) begin
                        dm_done_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = cap_data;
                        end
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = cap_data;
                    end
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign if_ready    = if_done_q;
    assign dm_ready    = dm_done_q;
    assign err         = err_q;

    assign pc_write_en = adv & hz_pc_we;
    assign ifid_en     = adv & hz_ifid_en;
    assign idex_en     = adv & hz_idex_en;
    assign exmem_en    = adv & hz_exmem_en;
    assign memwb_en    = adv & hz_memwb_en;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory with configurable wait states,
// an access-order scoreboard and a per-slot result scoreboard.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int NEVER = 1000;
    localparam int TMO_BUSY = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, dm_req, dm_we;
    logic [AW-1:0] if_addr, dm_addr, mem_addr;
    logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic          if_ready, dm_ready, mem_en, mem_we, mem_ack, err;
    logic          hz_pc_we, hz_ifid_en, hz_idex_en, hz_exmem_en, hz_memwb_en;
    logic          pc_write_en, ifid_en, idex_en, exmem_en, memwb_en;

    int checks = 0;
    int errors = 0;
    int waits = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } acc_t;

    typedef struct {
        int            cycles;
        logic [4:0]    en;
        logic          if_rdy;
        logic          dm_rdy;
        logic [DW-1:0] if_data;
        logic [DW-1:0] dm_data;
        logic          err;
    } exp_t;

    acc_t acc_q[$];
    exp_t slot_q[$];
    acc_t cur_acc;
    logic mem_en_prev = 1'b0;

    logic [DW-1:0] if_model = '0;
    logic [DW-1:0] dm_model = '0;
    logic          err_model = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hz_pc_we(hz_pc_we), .hz_ifid_en(hz_ifid_en), .hz_idex_en(hz_idex_en),
        .hz_exmem_en(hz_exmem_en), .hz_memwb_en(hz_memwb_en),
        .pc_write_en(pc_write_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .err(err)
    );

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        case (a)
            32'h0000_0010: rd_model = 32'h8C22_0004;
            32'h0000_0100: rd_model = 32'hDEAD_BEEF;
            default:       rd_model = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Memory model: acks after `waits` extra busy cycles; junk data whenever not acking.
    always @(posedge clk) begin
        if (mem_en) busy_cnt <= busy_cnt + 1;
        else        busy_cnt <= 0;
    end
    assign mem_ack   = mem_en && (busy_cnt == waits);
    assign mem_rdata = mem_ack ? rd_model(mem_addr) : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] en_vec();
        return {pc_write_en, ifid_en, idex_en, exmem_en, memwb_en};
    endfunction

    // Access-order scoreboard plus stability of the memory command while busy.
    always @(negedge clk) begin
        if (rst_n && mem_en) begin
            if (!mem_en_prev) begin
                if (acc_q.size() == 0) begin
                    chk("acc_unexpected", 64'd1, 64'd0);
                end else begin
                    cur_acc = acc_q.pop_front();
                end
            end
            chk("mem_addr", mem_addr, cur_acc.addr);
            chk("mem_we", mem_we, cur_acc.we);
            if (cur_acc.we) chk("mem_wdata", mem_wdata, cur_acc.wdata);
        end
        mem_en_prev <= mem_en;
    end

    task automatic run_slot(input logic ireq, input logic [AW-1:0] iaddr,
                            input logic dreq, input logic dwe,
                            input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
                            input int w, input logic [4:0] hz);
        exp_t e;
        acc_t a;
        int   n_acc;
        int   busy;
        int   cyc;
        bit   to;
        to    = (w >= NEVER);
        n_acc = int'(ireq) + int'(dreq);
        busy  = to ? TMO_BUSY : w + 1;
        if (dreq) begin
            a.addr = daddr; a.we = dwe; a.wdata = dwd;
            acc_q.push_back(a);
            if (!dwe) dm_model = to ? '0 : rd_model(daddr);
        end
        if (ireq) begin
            a.addr = iaddr; a.we = 1'b0; a.wdata = '0;
            acc_q.push_back(a);
            if_model = to ? '0 : rd_model(iaddr);
        end
        if (to && n_acc > 0) err_model = 1'b1;
        e.cycles  = 1 + n_acc * (1 + busy);
        e.en      = hz;
        e.if_rdy  = ireq;
        e.dm_rdy  = dreq;
        e.if_data = if_model;
        e.dm_data = dm_model;
        e.err     = err_model;
        slot_q.push_back(e);

        @(posedge clk); #1;
        if_req = ireq; if_addr = iaddr;
        dm_req = dreq; dm_we = dwe; dm_addr = daddr; dm_wdata = dwd;
        {hz_pc_we, hz_ifid_en, hz_idex_en, hz_exmem_en, hz_memwb_en} = hz;
        waits = w;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (en_vec() != 5'b0) break;
        end
        e = slot_q.pop_front();
        chk("slot_cycles", cyc, e.cycles);
        chk("enables", en_vec(), e.en);
        chk("if_ready", if_ready, e.if_rdy);
        chk("dm_ready", dm_ready, e.dm_rdy);
        if (e.if_rdy) chk("if_rdata", if_rdata, e.if_data);
        chk("dm_rdata", dm_rdata, e.dm_data);
        chk("err", err, e.err);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mem_en"}, mem_en, 1'b0);
        chk({tag, "_mem_we"}, mem_we, 1'b0);
        chk({tag, "_ready"}, {if_ready, dm_ready}, 2'b00);
        chk({tag, "_enables"}, en_vec(), 5'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_rdata"}, {if_rdata, dm_rdata}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100; dm_wdata = '0;
        {hz_pc_we, hz_ifid_en, hz_idex_en, hz_exmem_en, hz_memwb_en} = 5'b11111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst0");
        chk("rst0_mem_addr", mem_addr, 32'd0);
        chk("rst0_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0;
        rst_n = 1'b1;

        run_slot(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 5'b11111);
        run_slot(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 0, 5'b11111);
        run_slot(1'b1, 32'h14, 1'b1, 1'b0, 32'h100, 32'h0, 0, 5'b11111);
        run_slot(1'b1, 32'h18, 1'b1, 1'b1, 32'h200, 32'h1234_5678, 2, 5'b11111);
        run_slot(1'b1, 32'h1C, 1'b0, 1'b0, 32'h0, 32'h0, 0, 5'b00111);
        run_slot(1'b1, 32'h1C, 1'b0, 1'b0, 32'h0, 32'h0, 1, 5'b11111);
        run_slot(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, NEVER, 5'b11111);
        run_slot(1'b1, 32'h24, 1'b1, 1'b0, 32'h104, 32'h0, 0, 5'b11111);

        // Abandon a data read mid-access with a two-cycle reset.
        @(posedge clk); #1;
        acc_q.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0});
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; if_req = 1'b1; if_addr = 32'h28;
        waits = NEVER;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("rst1");
        @(posedge clk); #1;
        dm_req = 1'b0; if_req = 1'b0;
        rst_n = 1'b1;
        if_model = '0; dm_model = '0; err_model = 1'b0;

        run_slot(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 0, 5'b11111);
        chk("acc_q_drained", acc_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
